// File: rtl/speed_ramp_controller.sv
// Speed ramp controller: latches SPI speed commands, steps the applied speed toward
// the target at a fixed rate, drives a 16-slot PWM and trips a command watchdog.
module speed_ramp_controller #(
  parameter int RAMP_TICKS = 50000,
  parameter int PWM_DIV    = 16,
  parameter int WDT_TICKS  = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cmd_data_in,
  input  logic       cmd_valid_in,
  input  logic       enable_in,
  output logic [3:0] speed_out,
  output logic [3:0] target_out,
  output logic       pwm_out,
  output logic       busy_out,
  output logic       timeout_out,
  output logic [7:0] cmd_count_out
);

  localparam int SW = $clog2(RAMP_TICKS);
  localparam int WW = $clog2(WDT_TICKS);
  localparam int DW = $clog2(PWM_DIV + 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(RAMP_TICKS - 1);
  localparam logic [WW-1:0] WDT_LAST  = WW'(WDT_TICKS - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(PWM_DIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_UP, ST_DOWN, ST_HOLD} state_t;

  state_t        state_q, state_d;
  logic [3:0]    speed_q, speed_d;
  logic [3:0]    target_q, target_d;
  logic [SW-1:0] step_q, step_d;
  logic [WW-1:0] wdt_q, wdt_d;
  logic          timeout_q, timeout_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [3:0]    slot_q, slot_d;
  logic [DW-1:0] div_q, div_d;
  logic          pwm_q, pwm_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    speed_d   = speed_q;
    target_d  = target_q;
    step_d    = step_q;
    wdt_d     = wdt_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    slot_d    = slot_q;
    div_d     = div_q;

    if (div_q == DIV_LAST) begin
      div_d  = '0;
      slot_d = slot_q + 4'd1;
    end else begin
      div_d = div_q + DW'(1);
    end
    pwm_d = enable_in && (slot_q < speed_q);

    if (!enable_in) begin
      state_d  = ST_IDLE;
      speed_d  = '0;
      target_d = '0;
      step_d   = '0;
      wdt_d    = '0;
    end else begin
      // A command on the expiry edge takes precedence over the watchdog.
      if (cmd_valid_in) begin
        target_d  = cmd_data_in;
        cnt_d     = cnt_q + 8'd1;
        wdt_d     = '0;
        timeout_d = 1'b0;
      end else if (target_q != 4'd0) begin
        if (wdt_q == WDT_LAST) begin
          target_d  = '0;
          timeout_d = 1'b1;
          wdt_d     = '0;
        end else begin
          wdt_d = wdt_q + WW'(1);
        end
      end else begin
        wdt_d = '0;
      end

      // Step timer keeps running across retargets so a reversal never jumps speed.
      if (state_q == ST_UP || state_q == ST_DOWN) begin
        if (step_q == STEP_LAST) begin
          step_d = '0;
          if (speed_q < target_d)      speed_d = speed_q + 4'd1;
          else if (speed_q > target_d) speed_d = speed_q - 4'd1;
        end else begin
          step_d = step_q + SW'(1);
        end
      end else begin
        step_d = '0;
      end

      if (speed_d == target_d)     state_d = (target_d == 4'd0) ? ST_IDLE : ST_HOLD;
      else if (speed_d < target_d) state_d = ST_UP;
      else                         state_d = ST_DOWN;
    end

    busy_d = (state_d == ST_UP) || (state_d == ST_DOWN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      speed_q   <= '0;
      target_q  <= '0;
      step_q    <= '0;
      wdt_q     <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      slot_q    <= '0;
      div_q     <= '0;
      pwm_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      speed_q   <= speed_d;
      target_q  <= target_d;
      step_q    <= step_d;
      wdt_q     <= wdt_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      slot_q    <= slot_d;
      div_q     <= div_d;
      pwm_q     <= pwm_d;
      busy_q    <= busy_d;
    end
  end

  assign speed_out     = speed_q;
  assign target_out    = target_q;
  assign pwm_out       = pwm_q;
  assign busy_out      = busy_q;
  assign timeout_out   = timeout_q;
  assign cmd_count_out = cnt_q;

endmodule

// File: tb/tb_speed_ramp_controller.sv
// Directed bench for speed_ramp_controller with small ramp/watchdog parameters and
// hand-computed expected values; samples 1 ns after each rising edge.
module tb_speed_ramp_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cmd_data_in;
  logic       cmd_valid_in;
  logic       enable_in;
  logic [3:0] speed_out;
  logic [3:0] target_out;
  logic       pwm_out;
  logic       busy_out;
  logic       timeout_out;
  logic [7:0] cmd_count_out;

  int checks_n = 0;
  int fail_n   = 0;
  int hi_n;

  speed_ramp_controller #(.RAMP_TICKS(4), .PWM_DIV(1), .WDT_TICKS(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_data_in   (cmd_data_in),
    .cmd_valid_in  (cmd_valid_in),
    .enable_in     (enable_in),
    .speed_out     (speed_out),
    .target_out    (target_out),
    .pwm_out       (pwm_out),
    .busy_out      (busy_out),
    .timeout_out   (timeout_out),
    .cmd_count_out (cmd_count_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks_n++;
    if (got != exp) begin
      fail_n++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [3:0] v);
    cmd_data_in  = v;
    cmd_valid_in = 1'b1;
    cyc(1);
    cmd_valid_in = 1'b0;
  endtask

  initial begin
    reset = 1'b0; enable_in = 1'b1; cmd_valid_in = 1'b1; cmd_data_in = 4'd6;
    cyc(2);
    chk("rst_speed", speed_out, 0);
    chk("rst_target", target_out, 0);
    chk("rst_cnt", cmd_count_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_timeout", timeout_out, 0);
    chk("rst_pwm", pwm_out, 0);
    cmd_valid_in = 1'b0;
    reset = 1'b1;

    hi_n = 0;
    for (int i = 0; i < 16; i++) begin
      hi_n += int'(pwm_out);
      cyc(1);
    end
    chk("pwm_idle_low", hi_n, 0);

    // Ramp 0 -> 5
    send(4'd5);
    chk("up_target", target_out, 5);
    chk("up_busy", busy_out, 1);
    chk("up_speed0", speed_out, 0);
    chk("up_cnt", cmd_count_out, 1);
    cyc(3);
    chk("up_pre_step", speed_out, 0);
    cyc(1);
    chk("up_step1", speed_out, 1);
    for (int k = 2; k <= 5; k++) begin
      cyc(4);
      chk("up_step", speed_out, k);
    end
    chk("hold_busy", busy_out, 0);
    cyc(4);
    chk("hold_no_overshoot", speed_out, 5);

    // Watchdog: command at edge 0, expiry on edge 64; now at edge 24
    cyc(39);
    chk("wdt_pre_timeout", timeout_out, 0);
    chk("wdt_pre_target", target_out, 5);
    cyc(1);
    chk("wdt_timeout", timeout_out, 1);
    chk("wdt_target0", target_out, 0);
    chk("wdt_busy", busy_out, 1);
    for (int k = 4; k >= 0; k--) begin
      cyc(4);
      chk("wdt_rampdown", speed_out, k);
    end
    chk("wdt_idle_busy", busy_out, 0);
    send(4'd2);
    chk("wdt_clear", timeout_out, 0);
    chk("wdt_new_target", target_out, 2);
    chk("wdt_cnt", cmd_count_out, 2);
    cyc(8);
    chk("hold2_speed", speed_out, 2);

    // Command arriving on the expiry edge (edge 64 after the command 2)
    cyc(55);
    chk("race_pre", timeout_out, 0);
    send(4'd10);
    chk("race_timeout", timeout_out, 0);
    chk("race_target", target_out, 10);
    chk("race_cnt", cmd_count_out, 3);
    cyc(4);
    chk("retgt_speed3", speed_out, 3);

    // Retarget to 0 mid-ramp
    send(4'd0);
    chk("retgt_target", target_out, 0);
    chk("retgt_speed_hold", speed_out, 3);
    cyc(2);
    chk("retgt_no_jump", speed_out, 3);
    cyc(1);
    chk("retgt_step2", speed_out, 2);
    cyc(4);
    chk("retgt_step1", speed_out, 1);
    cyc(4);
    chk("retgt_step0", speed_out, 0);
    chk("retgt_idle", busy_out, 0);
    cyc(8);
    chk("retgt_no_underflow", speed_out, 0);

    // Emergency stop at speed 7
    send(4'd9);
    cyc(28);
    chk("estop_pre_speed", speed_out, 7);
    enable_in = 1'b0;
    cyc(1);
    chk("estop_speed", speed_out, 0);
    chk("estop_target", target_out, 0);
    chk("estop_pwm", pwm_out, 0);
    chk("estop_busy", busy_out, 0);
    send(4'd4);
    send(4'd4);
    chk("estop_cnt", cmd_count_out, 5);
    chk("estop_ign_target", target_out, 0);
    enable_in = 1'b1;

    // Full speed PWM duty
    send(4'd15);
    cyc(60);
    chk("full_speed", speed_out, 15);
    send(4'd15);
    chk("same_cmd_cnt", cmd_count_out, 7);
    chk("same_cmd_busy", busy_out, 0);
    hi_n = 0;
    for (int i = 0; i < 16; i++) begin
      hi_n += int'(pwm_out);
      cyc(1);
    end
    chk("pwm_duty15", hi_n, 15);

    // Counter wrap: 7 + 249 = 256
    for (int i = 0; i < 249; i++) send(4'd15);
    chk("cnt_wrap", cmd_count_out, 0);
    chk("cnt_wrap_speed", speed_out, 15);

    // Reset mid-ramp with a command in the reset cycle
    send(4'd3);
    cyc(4);
    chk("rmid_speed14", speed_out, 14);
    reset = 1'b0; cmd_valid_in = 1'b1; cmd_data_in = 4'd8;
    cyc(1);
    chk("rmid_speed", speed_out, 0);
    chk("rmid_target", target_out, 0);
    chk("rmid_cnt", cmd_count_out, 0);
    chk("rmid_busy", busy_out, 0);
    chk("rmid_pwm", pwm_out, 0);
    chk("rmid_timeout", timeout_out, 0);
    reset = 1'b1; cmd_valid_in = 1'b0;
    cyc(1);
    chk("rmid_drop_target", target_out, 0);
    chk("rmid_drop_cnt", cmd_count_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_n, fail_n);
    $finish;
  end

endmodule
